// File: rtl/muldiv_pkg.sv
// Shared types and opcode helpers for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } muldiv_state_e;

  function automatic logic is_div(muldiv_op_e op);
    return op[2];
  endfunction

  function automatic logic is_rem(muldiv_op_e op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

  function automatic logic is_signed_a(muldiv_op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_signed_b(muldiv_op_e op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the EXE stage and the multiply/divide unit.
interface muldiv_if #(
  parameter int unsigned XLEN = 32
);
  logic            start;
  logic            flush;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (output start, flush, op, a, b, input busy, done, result);
  modport slave  (input start, flush, op, a, b, output busy, done, result);
endinterface

// File: rtl/muldiv_step.sv
// One iteration of the datapath: shift-add multiply step or restoring divide step.
module muldiv_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic            is_div_i,
  input  logic [XLEN-1:0] hi_i,
  input  logic [XLEN-1:0] lo_i,
  input  logic [XLEN-1:0] md_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] diff;
  logic            ge;

  always_comb begin
    sum     = {1'b0, hi_i} + (lo_i[0] ? {1'b0, md_i} : '0);
    shifted = {hi_i, lo_i[XLEN-1]};
    ge      = (shifted >= {1'b0, md_i});
    // Partial remainder stays below the divisor, so the low XLEN bits of the difference suffice.
    diff    = shifted[XLEN-1:0] - md_i;
    if (is_div_i) begin
      hi_o = ge ? diff : shifted[XLEN-1:0];
      lo_o = {lo_i[XLEN-2:0], ge};
    end else begin
      hi_o = sum[XLEN:1];
      lo_o = {sum[0], lo_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/riscv_muldiv_unit.sv
// Iterative RV32M multiply/divide unit, one bit per cycle, result held until next accepted op.
// Optional `MULDIV_EARLY_OUT_EN: zero operands, divide-by-zero and signed overflow finish in one cycle.
module riscv_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter  int unsigned XLEN  = 32,
  localparam int unsigned CNT_W = $clog2(XLEN) + 1
) (
  input  logic    clk,
  input  logic    reset_n,
  muldiv_if.slave bus
);

  muldiv_state_e   state_q;
  muldiv_op_e      op_q;
  logic [XLEN-1:0] hi_q, lo_q, md_q, a_q;
  logic [CNT_W-1:0] cnt_q;
  logic            neg_q, rneg_q, div0_q, ovf_q;
  logic            busy_q, done_q;
  logic [XLEN-1:0] result_q;

  muldiv_op_e      op_in;
  logic            sa_in, sb_in, div0_in, ovf_in;
  logic [XLEN-1:0] mag_a, mag_b;

  logic [XLEN-1:0]   hi_d, lo_d;
  logic              step_is_div;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, fix_result_d;

  always_comb begin
    op_in   = muldiv_op_e'(bus.op);
    sa_in   = is_signed_a(op_in) & bus.a[XLEN-1];
    sb_in   = is_signed_b(op_in) & bus.b[XLEN-1];
    mag_a   = sa_in ? -bus.a : bus.a;
    mag_b   = sb_in ? -bus.b : bus.b;
    div0_in = is_div(op_in) && (bus.b == '0);
    ovf_in  = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
              (bus.a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.b == '1);
  end

`ifdef MULDIV_EARLY_OUT_EN
  logic            early_in;
  logic [XLEN-1:0] early_res;

  always_comb begin
    early_in  = (bus.a == '0) || (bus.b == '0) || ovf_in;
    early_res = '0;
    if (ovf_in)
      early_res = is_rem(op_in) ? '0 : bus.a;
    else if (div0_in)
      early_res = is_rem(op_in) ? bus.a : '1;
  end
`endif

  assign step_is_div = is_div(op_q);

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div_i (step_is_div),
    .hi_i     (hi_q),
    .lo_i     (lo_q),
    .md_i     (md_q),
    .hi_o     (hi_d),
    .lo_o     (lo_d)
  );

  always_comb begin
    prod   = {hi_q, lo_q};
    prod_s = neg_q ? -prod : prod;
    quo_s  = neg_q ? -lo_q : lo_q;
    rem_s  = rneg_q ? -hi_q : hi_q;
    fix_result_d = '0;
    if (is_div(op_q)) begin
      if (div0_q)
        fix_result_d = is_rem(op_q) ? a_q : '1;
      else if (ovf_q)
        fix_result_d = is_rem(op_q) ? '0 : a_q;
      else
        fix_result_d = is_rem(op_q) ? rem_s : quo_s;
    end else begin
      fix_result_d = (op_q == OP_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      op_q     <= OP_MUL;
      hi_q     <= '0;
      lo_q     <= '0;
      md_q     <= '0;
      a_q      <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      div0_q   <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start && !bus.flush) begin
            op_q   <= op_in;
            a_q    <= bus.a;
            hi_q   <= '0;
            // Divide keeps the dividend in lo; multiply keeps the multiplier there.
            lo_q   <= is_div(op_in) ? mag_a : mag_b;
            md_q   <= is_div(op_in) ? mag_b : mag_a;
            neg_q  <= sa_in ^ sb_in;
            rneg_q <= sa_in;
            div0_q <= div0_in;
            ovf_q  <= ovf_in;
            cnt_q  <= CNT_W'(XLEN - 1);
            busy_q <= 1'b1;
`ifdef MULDIV_EARLY_OUT_EN
            if (early_in) begin
              result_q <= early_res;
              done_q   <= 1'b1;
              state_q  <= DONE;
            end else begin
              state_q  <= CALC;
            end
`else
            state_q <= CALC;
`endif
          end
        end
        CALC: begin
          if (bus.flush) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == '0)
              state_q <= FIX;
          end
        end
        FIX: begin
          if (bus.flush) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            result_q <= fix_result_d;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// Scoreboard bench for riscv_muldiv_unit: random ops against an arithmetic reference model.
module tb_riscv_muldiv_unit;

  localparam int XLEN = 32;
  localparam logic [31:0] MINV = 32'h8000_0000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  muldiv_if #(.XLEN(XLEN)) bus();

  riscv_muldiv_unit #(.XLEN(XLEN)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [31:0] res;
    int          acc;
    int          lat;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  logic [31:0] last_res = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h required %08h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] p;
    logic [63:0]        u;
    logic signed [31:0] sa, sb;
    logic [31:0]        r;
    sa = a;
    sb = b;
    r  = '0;
    case (op)
      3'd0: r = a * b;
      3'd1: begin p = 64'(sa) * 64'(sb); r = p[63:32]; end
      3'd2: begin p = 64'(sa) * $signed({32'b0, b}); r = p[63:32]; end
      3'd3: begin u = {32'b0, a} * {32'b0, b}; r = u[63:32]; end
      3'd4: if (b == 0) r = '1; else if (a == MINV && b == '1) r = a; else r = sa / sb;
      3'd5: if (b == 0) r = '1; else r = a / b;
      3'd6: if (b == 0) r = a; else if (a == MINV && b == '1) r = '0; else r = sa % sb;
      default: if (b == 0) r = a; else r = a % b;
    endcase
    return r;
  endfunction

  function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    if (a == 0 || b == 0 || ((op == 3'd4 || op == 3'd6) && a == MINV && b == '1)) return 1;
`else
    if (op == 3'd7 && a == 0 && b == 0) return 34;
`endif
    return 34;
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0: v = '0;
      1: v = 32'd1;
      2: v = '1;
      3: v = MINV;
      4: v = 32'h7fff_ffff;
      5: v = $urandom_range(0, 255);
      6: begin v = $urandom_range(1, 255); v = -v; end
      default: v = $urandom;
    endcase
    return v;
  endfunction

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit track);
    int t;
    t = 0;
    @(negedge clk);
    while (bus.busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      n_checks++;
      $display("FAIL issue_wait: busy=1 after 100 cycles, required 0");
    end
    bus.op = op; bus.a = a; bus.b = b; bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    if (track) begin
      sb_q.push_back('{res: model(op, a, b), acc: cyc, lat: exp_lat(op, a, b)});
      last_res = model(op, a, b);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      n_checks++;
      $display("FAIL drain: %0d ops outstanding after 200 cycles, required 0", sb_q.size());
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset_n && bus.done) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_done: got done=1 result=%08h, required no done", bus.result);
      end else begin
        e = sb_q.pop_front();
        check32("result", bus.result, e.res);
        check_int("latency", cyc - e.acc + 1, e.lat);
        check32("busy_at_done", 32'(bus.busy), 32'd1);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0; bus.flush = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
    #12;
    check32("reset_busy", 32'(bus.busy), 32'd0);
    check32("reset_done", 32'(bus.done), 32'd0);
    check32("reset_result", bus.result, 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Directed cases
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    issue(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    issue(3'd1, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    issue(3'd4, -32'd7, 32'd2, 1);
    issue(3'd6, -32'd7, 32'd2, 1);
    issue(3'd5, 32'd7, 32'd2, 1);
    issue(3'd4, 32'd5, 32'd0, 1);
    issue(3'd6, 32'd5, 32'd0, 1);
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    issue(3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    drain();

    // Starts during a DIVU are ignored
    issue(3'd5, 32'd1000003, 32'd7, 1);
    repeat (5) @(negedge clk);
    bus.op = 3'd0; bus.a = 32'd99; bus.b = 32'd3; bus.start = 1'b1;
    repeat (16) @(negedge clk);
    bus.start = 1'b0;
    drain();
    repeat (40) @(negedge clk);
    check32("idle_after_ignored", 32'(bus.busy), 32'd0);

    // Flush in cycle 10 aborts without done
    issue(3'd3, 32'h1234_5678, 32'h9abc_def0, 0);
    repeat (10) @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    check32("flush_busy", 32'(bus.busy), 32'd0);
    check32("flush_done", 32'(bus.done), 32'd0);
    check32("flush_result", bus.result, last_res);
    repeat (40) @(negedge clk);
    check32("flush_result_held", bus.result, last_res);

    // Flush beats a simultaneous start
    @(negedge clk);
    bus.op = 3'd0; bus.a = 32'd3; bus.b = 32'd4; bus.start = 1'b1; bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    check32("flush_wins_busy", 32'(bus.busy), 32'd0);
    repeat (40) @(negedge clk);

    // Asynchronous reset in mid-CALC
    issue(3'd4, 32'd123456, 32'd789, 0);
    repeat (15) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check32("areset_busy", 32'(bus.busy), 32'd0);
    check32("areset_done", 32'(bus.done), 32'd0);
    check32("areset_result", bus.result, 32'd0);
    last_res = '0;
    @(negedge clk);
    reset_n = 1'b1;
    issue(3'd1, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1);
    drain();

    // Random back-to-back traffic
    for (int i = 0; i < 150; i++)
      issue(3'($urandom_range(0, 7)), pick(), pick(), 1);
    drain();
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
